// File: rtl/sched_pkg.sv
// Shared types and constants for the instruction scheduler: FSM states,
// opcode values and instruction field positions.
package sched_pkg;

  localparam int W_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_S1       = 3'd1,
    ST_S2       = 3'd2,
    ST_S3       = 3'd3,
    ST_WAIT_IMM = 3'd4
  } state_e;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;

  localparam int OP_HI = 9;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 4;
  localparam int RY_HI = 3;
  localparam int RY_LO = 2;

endpackage

// File: rtl/instr_scheduler_if.sv
// Valid/ready word stream feeding the scheduler FIFO.
interface instr_scheduler_if #(parameter int W = sched_pkg::W_DEFAULT);
  logic         IN_VALID;
  logic [W-1:0] IN_WORD;
  logic         IN_READY;

  modport master (output IN_VALID, output IN_WORD, input IN_READY);
  modport slave  (input IN_VALID, input IN_WORD, output IN_READY);
endinterface

// File: rtl/sched_fifo.sv
// Synchronous FIFO with registered head, full/empty and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sched_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // pointer and count update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok_s) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

endmodule

// File: rtl/instr_scheduler.sv
// Multi-cycle instruction scheduler producing T0-T3 datapath strobes.
// Optional single-step gating via the SCHED_STEP_EN macro (adds a STEP port).
module instr_scheduler
  import sched_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         CLR,
`ifdef SCHED_STEP_EN
  input  logic         STEP,
`endif
  instr_scheduler_if.slave in_if,
  output logic [W-1:0] IMM,
  output logic         EXT,
  output logic [1:0]   RIN,
  output logic         ENW,
  output logic [1:0]   ROUT,
  output logic         ENR,
  output logic         AIN,
  output logic         GIN,
  output logic         GOUT,
  output logic [3:0]   ALU_FN,
  output logic [1:0]   T,
  output logic         BUSY,
  output logic         DONE
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [W-1:0]  ir_q, ir_d;
  logic          adv_s;
  logic          push_s, pop_s;
  logic [W-1:0]  head_s;
  logic          full_s, empty_s;
  logic [AW:0]   cnt_unused_s;
  logic [1:0]    ir_unused_s;
  logic [3:0]    op_s;
  logic [1:0]    rx_s, ry_s;

  logic [W-1:0]  imm_s;
  logic          ext_s, enw_s, enr_s, ain_s, gin_s, gout_s, done_s;
  logic [1:0]    rin_s, rout_s, t_s;
  logic [3:0]    fn_s;

`ifdef SCHED_STEP_EN
  assign adv_s = STEP;
`else
  assign adv_s = 1'b1;
`endif

  assign op_s        = ir_q[OP_HI:OP_LO];
  assign rx_s        = ir_q[RX_HI:RX_LO];
  assign ry_s        = ir_q[RY_HI:RY_LO];
  assign ir_unused_s = ir_q[1:0];

  assign in_if.IN_READY = !full_s && !CLR;
  assign push_s         = in_if.IN_VALID && in_if.IN_READY;

  sched_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (CLR),
    .push_i  (push_s),
    .din_i   (in_if.IN_WORD),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (cnt_unused_s)
  );

  // state and instruction register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // next-state, FIFO pop and per-step strobe decode
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pop_s   = 1'b0;
    imm_s   = '0;
    ext_s   = 1'b0;
    rin_s   = 2'd0;
    enw_s   = 1'b0;
    rout_s  = 2'd0;
    enr_s   = 1'b0;
    ain_s   = 1'b0;
    gin_s   = 1'b0;
    gout_s  = 1'b0;
    fn_s    = 4'd0;
    t_s     = 2'd0;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && adv_s) begin
          pop_s   = 1'b1;
          ir_d    = head_s;
          state_d = ST_S1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_S1, ST_WAIT_IMM: begin
        t_s = 2'd1;
        if (op_s == OP_LOAD) begin
          // immediate comes straight from the FIFO head; wait here until it arrives
          if (!empty_s) begin
            imm_s  = head_s;
            ext_s  = 1'b1;
            rin_s  = rx_s;
            enw_s  = 1'b1;
            done_s = 1'b1;
            if (adv_s) begin
              pop_s   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = state_q;
            end
          end else if (adv_s) begin
            state_d = ST_WAIT_IMM;
          end else begin
            state_d = state_q;
          end
        end else if (op_s == OP_MOV) begin
          rout_s = ry_s;
          enr_s  = 1'b1;
          rin_s  = rx_s;
          enw_s  = 1'b1;
          done_s = 1'b1;
          if (adv_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else begin
          rout_s = rx_s;
          enr_s  = 1'b1;
          ain_s  = 1'b1;
          if (adv_s) begin
            state_d = ST_S2;
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_S2: begin
        t_s    = 2'd2;
        rout_s = ry_s;
        enr_s  = 1'b1;
        gin_s  = 1'b1;
        fn_s   = op_s;
        if (adv_s) begin
          state_d = ST_S3;
        end else begin
          state_d = ST_S2;
        end
      end
      ST_S3: begin
        t_s    = 2'd3;
        gout_s = 1'b1;
        rin_s  = rx_s;
        enw_s  = 1'b1;
        done_s = 1'b1;
        if (adv_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_S3;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // reset suppresses every strobe; write-type strobes also follow the step gate
  always_comb begin
    IMM    = CLR ? '0 : imm_s;
    EXT    = ext_s && !CLR;
    RIN    = CLR ? 2'd0 : rin_s;
    ENW    = enw_s && adv_s && !CLR;
    ROUT   = CLR ? 2'd0 : rout_s;
    ENR    = enr_s && !CLR;
    AIN    = ain_s && adv_s && !CLR;
    GIN    = gin_s && adv_s && !CLR;
    GOUT   = gout_s && !CLR;
    ALU_FN = CLR ? 4'd0 : fn_s;
    T      = CLR ? 2'd0 : t_s;
    BUSY   = (state_q != ST_IDLE) && !CLR;
    DONE   = done_s && adv_s && !CLR;
  end

endmodule

// File: tb/tb_instr_scheduler.sv
// Randomised self-checking bench for instr_scheduler against a queue-based
// behavioural model of instruction execution.
module tb_instr_scheduler;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [9:0] IMM;
  logic       EXT, ENW, ENR, AIN, GIN, GOUT, BUSY, DONE;
  logic [1:0] RIN, ROUT, T;
  logic [3:0] ALU_FN;

  instr_scheduler_if #(.W(10)) ifc ();

  instr_scheduler #(.W(10), .DEPTH(4)) dut (
    .CLK    (CLK),
    .CLR    (CLR),
`ifdef SCHED_STEP_EN
    .STEP   (1'b1),
`endif
    .in_if  (ifc),
    .IMM    (IMM),
    .EXT    (EXT),
    .RIN    (RIN),
    .ENW    (ENW),
    .ROUT   (ROUT),
    .ENR    (ENR),
    .AIN    (AIN),
    .GIN    (GIN),
    .GOUT   (GOUT),
    .ALU_FN (ALU_FN),
    .T      (T),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [9:0] mq[$];
  logic [9:0] sq[$];
  bit         m_busy = 1'b0;
  logic [9:0] m_ir   = 10'd0;
  int         m_t    = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step_cycle(input bit clr, input bit allow);
    logic [9:0] e_imm;
    logic [3:0] op, e_fn;
    logic [1:0] rx, ry, e_rin, e_rout, e_t;
    bit e_ext, e_enw, e_enr, e_ain, e_gin, e_gout, e_busy, e_done, e_rdy, acc;
    CLR          = clr;
    ifc.IN_VALID = allow && (sq.size() != 0);
    ifc.IN_WORD  = (sq.size() != 0) ? sq[0] : 10'($urandom);
    @(negedge CLK);
    e_imm = 10'd0; e_fn = 4'd0; e_rin = 2'd0; e_rout = 2'd0; e_t = 2'd0;
    e_ext = 0; e_enw = 0; e_enr = 0; e_ain = 0; e_gin = 0; e_gout = 0; e_busy = 0; e_done = 0;
    e_rdy = !clr && (mq.size() < 4);
    op = m_ir[9:6]; rx = m_ir[5:4]; ry = m_ir[3:2];
    if (!clr && m_busy) begin
      e_busy = 1;
      e_t    = 2'(m_t);
      if (op == 4'd0) begin
        if (mq.size() > 0) begin
          e_ext = 1; e_imm = mq[0]; e_rin = rx; e_enw = 1; e_done = 1;
        end
      end else if (op == 4'd1) begin
        e_rout = ry; e_enr = 1; e_rin = rx; e_enw = 1; e_done = 1;
      end else if (m_t == 1) begin
        e_rout = rx; e_enr = 1; e_ain = 1;
      end else if (m_t == 2) begin
        e_rout = ry; e_enr = 1; e_gin = 1; e_fn = op;
      end else begin
        e_gout = 1; e_rin = rx; e_enw = 1; e_done = 1;
      end
    end
    chk_eq("in_ready", ifc.IN_READY, e_rdy);
    chk_eq("busy", BUSY, e_busy);
    chk_eq("t", T, e_t);
    chk_eq("done", DONE, e_done);
    chk_eq("ext", EXT, e_ext);
    chk_eq("imm", IMM, e_imm);
    chk_eq("rin", RIN, e_rin);
    chk_eq("enw", ENW, e_enw);
    chk_eq("rout", ROUT, e_rout);
    chk_eq("enr", ENR, e_enr);
    chk_eq("ain", AIN, e_ain);
    chk_eq("gin", GIN, e_gin);
    chk_eq("gout", GOUT, e_gout);
    chk_eq("alu_fn", ALU_FN, e_fn);
    chk_eq("one_driver", 32'(EXT) + 32'(ENR) + 32'(GOUT) <= 32'd1, 1);
    acc = ifc.IN_VALID && e_rdy;
    if (clr) begin
      mq.delete();
      m_busy = 0; m_ir = 10'd0; m_t = 0;
    end else begin
      if (!m_busy) begin
        if (mq.size() > 0) begin
          m_ir = mq.pop_front(); m_busy = 1; m_t = 1;
        end
      end else if (op == 4'd0) begin
        if (mq.size() > 0) begin
          void'(mq.pop_front()); m_busy = 0; m_t = 0;
        end
      end else if (op == 4'd1 || m_t == 3) begin
        m_busy = 0; m_t = 0;
      end else begin
        m_t++;
      end
      if (acc) mq.push_back(ifc.IN_WORD);
    end
    if (acc) void'(sq.pop_front());
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    ifc.IN_VALID = 1'b0;
    ifc.IN_WORD  = 10'd0;
    @(posedge CLK);
    #1;
    // reset with a word offered: nothing may be accepted
    sq.push_back(10'h020);
    step_cycle(1'b1, 1'b1);
    step_cycle(1'b1, 1'b1);
    sq.delete();
    step_cycle(1'b0, 1'b0);
    // LOAD with immediate already queued
    sq.push_back(10'h020); sq.push_back(10'h155);
    repeat (6) step_cycle(1'b0, 1'b1);
    // LOAD with the immediate arriving late
    sq.push_back(10'h020);
    step_cycle(1'b0, 1'b1);
    sq.push_back(10'h155);
    repeat (3) step_cycle(1'b0, 1'b0);
    repeat (5) step_cycle(1'b0, 1'b1);
    // ALU op followed by a burst of five MOVs against a 4-deep FIFO
    sq.push_back(10'h09C);
    for (int i = 0; i < 5; i++) sq.push_back({4'b0001, 2'(i), 2'(3 - i), 2'b00});
    repeat (30) step_cycle(1'b0, 1'b1);
    // reset in S2 of an ALU op with two MOVs queued
    sq.push_back(10'h09C); sq.push_back(10'h050); sq.push_back(10'h064);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_busy && m_t == 2 && m_ir[9:6] >= 4'd2) found = 1'b1;
      else step_cycle(1'b0, 1'b1);
    end
    chk_eq("reach_s2", found, 1'b1);
    sq.delete();
    step_cycle(1'b1, 1'b0);
    repeat (3) step_cycle(1'b0, 1'b0);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (sq.size() < 2) sq.push_back(10'($urandom));
      step_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
    end
    sq.delete();
    repeat (10) step_cycle(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_scheduler.md
# instr_scheduler

Multi-cycle instruction scheduler for the 10-bit bus datapath: register file, ALU A/G registers and the external-data tri-state buffer. Instruction and immediate words arrive over a valid/ready handshake and are buffered in a small FIFO. Each instruction is decoded and stepped through T0–T3, producing the per-cycle bus-driver and register-enable strobes. It replaces manual, key-driven timestep sequencing, so programs can be streamed into the datapath back-to-back.

## Interface
Parameters:
- `W`, 10: instruction/data word width
- `DEPTH`, 4: FIFO entries (power of two, ≥2)

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `CLR`  in  1  reset, synchronous, active-high
- `IN_VALID`  in  1  producer offers `IN_WORD`
- `IN_WORD`  in  W  instruction or immediate word
- `IN_READY`  out  1  FIFO can accept; a push occurs when `IN_VALID & IN_READY`
- `IMM`  out  W  immediate value driven onto the bus when `EXT` is high
- `EXT`  out  1  external/immediate bus-drive enable
- `RIN`  out  2  register-file write address
- `ENW`  out  1  register-file write enable
- `ROUT`  out  2  register-file read address
- `ENR`  out  1  register-file bus-drive enable
- `AIN`, `GIN`, `GOUT`  out  1 each  ALU operand latch, result latch, result bus drive
- `ALU_FN`  out  4  ALU function select
- `T`  out  2  current timestep
- `BUSY`  out  1  instruction in progress
- `DONE`  out  1  one-cycle pulse on an instruction's final step

## Operation
- Instruction format:
  - `[9:6]` opcode, `[5:4]` Rx, `[3:2]` Ry, `[1:0]` ignored.
  - `0000` LOAD Rx,#imm: the next FIFO word is the immediate.
  - `0001` MOV Rx,Ry.
  - `0010`–`1111` ALU: Rx ← Rx op Ry, with `ALU_FN` = opcode.
- FSM states: `IDLE`, `S1`, `S2`, `S3`, `WAIT_IMM`.
- `IDLE` (T=0):
  - If the FIFO is non-empty: pop the head into the internal IR, then go to `S1`.
  - Otherwise stay in `IDLE`.
- LOAD:
  - In `S1`, if the FIFO is non-empty: pop the immediate. Drive `IMM` = popped word, `EXT`=1, `RIN`=Rx, `ENW`=1, `DONE`=1. Next state `IDLE`.
  - If the FIFO is empty: go to `WAIT_IMM`. All strobes stay 0 and `T` holds at 1.
  - `WAIT_IMM` completes exactly as `S1` does once the FIFO is non-empty.
- MOV, `S1`: `ROUT`=Ry, `ENR`=1, `RIN`=Rx, `ENW`=1, `DONE`=1. Next state `IDLE`.
- ALU:
  - `S1`: `ROUT`=Rx, `ENR`=1, `AIN`=1.
  - `S2`: `ROUT`=Ry, `ENR`=1, `GIN`=1, `ALU_FN`=op.
  - `S3`: `GOUT`=1, `RIN`=Rx, `ENW`=1, `DONE`=1. Next state `IDLE`.
- Outputs are Moore-decoded from the registered state, IR and FIFO head; no added latency.
- Idle output values:
  - All enables are 0.
  - `RIN`, `ROUT`, `ALU_FN` and `IMM` are 0 whenever their qualifying enable is 0.
- At most one bus driver (`EXT`, `ENR`, `GOUT`) is high in any cycle.
- `BUSY` = state ≠ `IDLE`.

## Timing
- Reset (`CLR` high, checked at the edge):
  - FSM goes to `IDLE`, FIFO is empty, IR = 0, `T`=0.
  - All strobes, `BUSY` and `DONE` are 0.
  - `IN_READY`=0 while `CLR`=1 and 1 on the first cycle after it drops.
- `CLR` mid-instruction abandons the instruction. No further strobe is issued, and FIFO contents are discarded.
- `IN_READY` = !full. It does not depend on a pop in the same cycle, so a full FIFO refuses a push even while popping.
- Push to an empty FIFO: the word is visible for a pop on the next cycle; there is no bypass.
- Latency from a word being pushed into an empty FIFO with the FSM in `IDLE`:
  - Pop happens 1 cycle after the push.
  - MOV: `DONE` 1 cycle after the pop.
  - ALU: `DONE` 3 cycles after the pop.
  - LOAD: `DONE` 1 cycle after the pop when its immediate is already queued.
- Back-to-back throughput, counting the `IDLE` pop cycle: MOV 2, LOAD 2, ALU 4 cycles per instruction.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits.
- `T` = 0/1/2/3 for `IDLE`/`S1`/`S2`/`S3`, and 1 in `WAIT_IMM`.

## Configuration
- `SCHED_STEP_EN` defined:
  - Adds input port `STEP` (1 bit).
  - FSM transitions and FIFO pops occur only in cycles with `STEP`=1.
  - `ENW`, `AIN`, `GIN` and `DONE` are gated with `STEP`. Addresses, `EXT`/`ENR`/`GOUT`, `IMM` and `T` hold for the whole step.
  - FIFO pushes are unaffected.
- `SCHED_STEP_EN` undefined: no `STEP` port; the FSM advances every cycle.

## Structure
- Package `sched_pkg`:
  - state enum
  - opcode constants `OP_LOAD`, `OP_MOV`
  - instruction field slice localparams
  - `W` default
- Sub-module `sched_fifo`: parameterised synchronous FIFO with push/pop, full/empty and count outputs. The FSM and decode stay in `instr_scheduler`.

## Test plan
- Reset: `CLR`=1 for 2 cycles with `IN_VALID`=1, `IN_WORD`=0x020 → `IN_READY`=0, nothing pushed, all outputs 0; after release the FIFO is empty and `BUSY`=0.
- LOAD: push 0x020 then 0x155 → pop cycle `T`=0, next cycle `EXT`=1, `IMM`=0x155, `RIN`=2, `ENW`=1, `DONE`=1, then `IDLE`.
- LOAD with the immediate pushed 3 cycles late → `WAIT_IMM`, `T`=1, all strobes 0, then completion 1 cycle after the immediate's push.
- ALU: push 0x09C (op 0010, R1, R3) → `S1`: `ROUT`=1, `ENR`, `AIN`; `S2`: `ROUT`=3, `ENR`, `GIN`, `ALU_FN`=0010; `S3`: `GOUT`, `RIN`=1, `ENW`, `DONE`.
- Flow control: with an ALU op executing, push 5 MOVs back-to-back → `IN_READY` drops after the 4th accepted; the 5th is accepted only once a pop frees a slot; all 5 execute in order.
- `CLR` asserted in `S2` of an ALU op with 2 words queued → next cycle `IDLE`, no `ENW`/`DONE`, FIFO empty, `IN_READY`=1.
